// File: rtl/hilo_unit.sv
// HI/LO register block with a multi-cycle multiply/divide engine (1-cycle MUL, 32-step restoring DIV + sign fix).
// Optional macro HILO_FWD_EN: rd_data bypasses a same-cycle wr_hi/wr_lo write.
module hilo_unit #(
  parameter int unsigned DIV_CYCLES = 32,
  parameter logic [31:0] RESET_VAL  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op_sel,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  input  logic        flush,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [5:0] LAST_ITER = 6'(DIV_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] hi_d, lo_d;
  logic [31:0] opA_q, opA_d, opB_q, opB_d;
  logic [31:0] quot_q, quot_d, rem_q, rem_d, divisor_q, divisor_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        opSigned_q, opSigned_d;
  logic        quotNeg_q, quotNeg_d, remNeg_q, remNeg_d;

  logic [63:0] mulA, mulB, product;
  logic [32:0] shifted;
  logic [31:0] quotFix, remFix;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      hi_q       <= RESET_VAL;
      lo_q       <= RESET_VAL;
      opA_q      <= '0;
      opB_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      cnt_q      <= '0;
      opSigned_q <= 1'b0;
      quotNeg_q  <= 1'b0;
      remNeg_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      divisor_q  <= divisor_d;
      cnt_q      <= cnt_d;
      opSigned_q <= opSigned_d;
      quotNeg_q  <= quotNeg_d;
      remNeg_q   <= remNeg_d;
    end
  end

  // Two's-complement product modulo 2^64 gives the signed result when operands are sign-extended.
  always_comb begin
    mulA    = opSigned_q ? {{32{opA_q[31]}}, opA_q} : {32'b0, opA_q};
    mulB    = opSigned_q ? {{32{opB_q[31]}}, opB_q} : {32'b0, opB_q};
    product = mulA * mulB;
    shifted = {rem_q, quot_q[31]};
    quotFix = quotNeg_q ? -quot_q : quot_q;
    remFix  = remNeg_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    divisor_d  = divisor_q;
    cnt_d      = cnt_q;
    opSigned_d = opSigned_q;
    quotNeg_d  = quotNeg_q;
    remNeg_d   = remNeg_q;

    if (wr_hi) hi_d = wr_data;
    if (wr_lo) lo_d = wr_data;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            opA_d      = src_a;
            opB_d      = src_b;
            opSigned_d = ~op_sel[0];
            if (op_sel[1]) begin
              state_d   = DIV;
              quot_d    = (~op_sel[0] && src_a[31]) ? -src_a : src_a;
              divisor_d = (~op_sel[0] && src_b[31]) ? -src_b : src_b;
              rem_d     = '0;
              cnt_d     = '0;
              quotNeg_d = ~op_sel[0] & (src_a[31] ^ src_b[31]);
              remNeg_d  = ~op_sel[0] & src_a[31];
            end else begin
              state_d = MUL;
            end
          end
        end
        MUL: begin
          hi_d    = product[63:32];
          lo_d    = product[31:0];
          state_d = IDLE;
        end
        DIV: begin
          if (shifted >= {1'b0, divisor_q}) begin
            rem_d  = 32'(shifted - {1'b0, divisor_q});
            quot_d = {quot_q[30:0], 1'b1};
          end else begin
            rem_d  = shifted[31:0];
            quot_d = {quot_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) state_d = FIX;
        end
        FIX: begin
          // Divide by zero reports all-ones quotient and the raw dividend as remainder.
          if (opB_q == 32'd0) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = opA_q;
          end else begin
            lo_d = quotFix;
            hi_d = remFix;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

`ifdef HILO_FWD_EN
  always_comb begin
    if (rd_sel) rd_data = wr_hi ? wr_data : hi_q;
    else        rd_data = wr_lo ? wr_data : lo_q;
  end
`else
  assign rd_data = rd_sel ? hi_q : lo_q;
`endif

endmodule
